// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master with an Avalon-MM slave interface.
// Firmware issues START / WRITE / READ / STOP commands. The engine drives the
// open-drain SCL/SDA pads, samples ACK and read data, and waits while a slave
// stretches the clock.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   address[1:0]          0 DATA (TX write / RX read), 1 CMD/STATUS, 2 PRESCALE
//   chipselect, write_n   Avalon write strobe is chipselect & ~write_n
//   writedata[7:0]        register write data
//   readdata[7:0]         registered read data, 1-cycle latency
//   scl_in, sda_in        sampled pad levels
//   scl_oe, sda_oe        1 = pull the line low, 0 = release it
module i2c_byte_master #(
    parameter logic [7:0] PRESCALE_INIT = 8'd124
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t     state, state_nxt;
    logic [1:0] q;
    logic [7:0] cnt, qlen, prescale;
    logic [7:0] txdata, rxdata, tx_sh, rx_sh;
    logic [3:0] bitcnt;
    logic       f_stop, f_rw, f_rd, f_nack;
    logic       rx_nack;
    logic       scl_nxt, sda_nxt;

    logic wr_en, busy, cmd_go, hold, tick, last, sample;

    assign wr_en  = chipselect & ~write_n;
    assign busy   = (state != IDLE);
    assign cmd_go = wr_en && (address == 2'd1) && !busy;
    // A slave holds SCL low after we released it: freeze the quarter.
    assign hold   = ((q == 2'd1) || (q == 2'd2)) && !scl_oe && !scl_in;
    assign tick   = busy && !hold && (cnt == qlen);
    assign last   = tick && (q == 2'd3);
    assign sample = tick && (q == 2'd1) && (state == BIT);

    always_comb begin
        state_nxt = state;
        scl_nxt   = scl_oe;
        sda_nxt   = sda_oe;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    if (writedata[0])                     state_nxt = START;
                    else if (writedata[2] | writedata[3]) state_nxt = BIT;
                    else if (writedata[1])                state_nxt = STOP;
                end
            end
            START: begin
                case (q)
                    2'd0:    begin sda_nxt = 1'b0;                  end
                    2'd1:    begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                    2'd2:    begin scl_nxt = 1'b0; sda_nxt = 1'b1; end
                    default: begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                endcase
                if (last) state_nxt = f_rw ? BIT : (f_stop ? STOP : IDLE);
            end
            BIT: begin
                scl_nxt = (q == 2'd0) || (q == 2'd3);
                if (bitcnt == 4'd8) sda_nxt = f_rd ? ~f_nack : 1'b0;
                else                sda_nxt = f_rd ? 1'b0 : ~tx_sh[7];
                if (last && (bitcnt == 4'd8)) state_nxt = f_stop ? STOP : IDLE;
            end
            default: begin
                case (q)
                    2'd0:    begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                    2'd1:    begin scl_nxt = 1'b0; sda_nxt = 1'b1; end
                    default: begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                endcase
                if (last) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            q        <= '0;
            cnt      <= '0;
            qlen     <= '0;
            prescale <= PRESCALE_INIT;
            txdata   <= '0;
            rxdata   <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bitcnt   <= '0;
            f_stop   <= 1'b0;
            f_rw     <= 1'b0;
            f_rd     <= 1'b0;
            f_nack   <= 1'b0;
            rx_nack  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            readdata <= '0;
        end else begin
            state  <= state_nxt;
            scl_oe <= scl_nxt;
            sda_oe <= sda_nxt;

            if (wr_en && (address == 2'd0)) txdata   <= writedata;
            if (wr_en && (address == 2'd2)) prescale <= writedata;

            if (cmd_go) begin
                f_stop <= writedata[1];
                f_rw   <= writedata[2] | writedata[3];
                f_rd   <= writedata[3] & ~writedata[2];
                f_nack <= writedata[4];
                tx_sh  <= txdata;
                cnt    <= '0;
                q      <= '0;
                qlen   <= prescale;
                bitcnt <= '0;
            end else if (busy) begin
                // Quarter length is latched per quarter so PRESCALE writes
                // apply from the next quarter boundary.
                if (tick) begin
                    cnt  <= '0;
                    q    <= q + 2'd1;
                    qlen <= prescale;
                end else if (!hold) begin
                    cnt <= cnt + 8'd1;
                end
                if (sample) begin
                    if (bitcnt == 4'd8) begin
                        if (!f_rd) rx_nack <= sda_in;
                    end else begin
                        rx_sh <= {rx_sh[6:0], sda_in};
                        if (f_rd && (bitcnt == 4'd7)) rxdata <= {rx_sh[6:0], sda_in};
                    end
                end
                if (last && (state == BIT)) begin
                    bitcnt <= (bitcnt == 4'd8) ? 4'd0 : bitcnt + 4'd1;
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                end
            end

            case (address)
                2'd0:    readdata <= rxdata;
                2'd1:    readdata <= {6'b0, rx_nack, busy};
                2'd2:    readdata <= prescale;
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: an I2C slave/bus model, a
// transaction-level reference model for timing and data, and random traffic.
module tb_i2c_byte_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = '0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic       scl_in, sda_in, scl_oe, sda_oe;

    logic stretch = 1'b0;
    logic slave_low = 1'b0;
    assign scl_in = ~scl_oe & ~stretch;
    assign sda_in = ~sda_oe & ~slave_low;

    i2c_byte_master #(.PRESCALE_INIT(8'd124)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- bus monitor / slave model ----------------
    bit         mon = 0, pmon = 0;
    int         slave_mode = 0;      // 0 absent, 1 ACK a write, 2 send slave_byte
    logic [7:0] slave_byte = '0;
    int         stretch_at = -1;
    int         mon_p = 3;
    int         nfall, nrise, nstop, stretch_left, lowlen;
    bit         started, armed, ack_oe_any;
    bit         pscl = 1, psda = 1, psoe = 0;
    logic       rise_bits [16];

    always @(negedge clk) begin
        bit scl_b, sda_b;
        if (!mon) begin
            slave_low = 1'b0;
            stretch   = 1'b0;
            armed     = 0;
        end else if (!pmon) begin
            started = 0; nfall = 0; nrise = 0; nstop = 0; ack_oe_any = 0;
            lowlen = 0; armed = 0; stretch = 1'b0; slave_low = 1'b0;
        end else begin
            if (stretch) begin
                stretch_left--;
                if (stretch_left == 0) stretch = 1'b0;
            end else if (armed && !scl_oe) begin
                stretch = 1'b1; stretch_left = 20; armed = 0;
            end
        end
        scl_b = !scl_oe && !stretch;
        sda_b = !sda_oe && !slave_low;
        if (mon && pmon) begin
            if (psda && pscl && scl_b && !sda_b) begin
                started = 1; nfall = 0; nrise = 0;
            end
            if (started && pscl && !scl_b) begin
                nfall++;
                if (slave_mode == 2)
                    slave_low = (nfall >= 1 && nfall <= 8) ? !slave_byte[8-nfall] : 1'b0;
                else if (slave_mode == 1)
                    slave_low = (nfall == 9);
                if (nfall == stretch_at + 1) armed = 1;
            end
            if (started && !pscl && scl_b && nrise < 16) begin
                rise_bits[nrise] = sda_b;
                nrise++;
            end
            if (started && pscl && scl_b && !psda && sda_b) nstop++;
            if (slave_mode == 2 && nfall == 9 && sda_oe) ack_oe_any = 1;
            if (scl_oe && !psoe) lowlen = 1;
            else if (scl_oe && lowlen > 0) lowlen++;
            else if (!scl_oe && psoe && lowlen > 0) begin
                check("scl_low_len", lowlen, 2 * (mon_p + 1));
                lowlen = 0;
            end
        end
        pmon = mon; pscl = scl_b; psda = sda_b; psoe = scl_oe;
    end

    // ---------------- register access ----------------
    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    bit exp_rxnack = 0;

    // One START..[STOP] transaction with a reference check of duration,
    // bit values on the bus, ACK handling and resulting registers.
    task automatic run_txn(input logic [7:0] p, input bit do_stop, input bit is_rd,
                           input bit nack, input logic [7:0] byte_v, input bit ack,
                           input int stretch_bit, input int inject);
        logic [7:0] cmd, rd;
        int exp_cycles, busy_cnt, quarters;
        bit seen, done;
        write_reg(2'd2, p);
        if (!is_rd) write_reg(2'd0, byte_v);
        slave_mode = is_rd ? 2 : (ack ? 1 : 0);
        slave_byte = byte_v;
        stretch_at = stretch_bit;
        mon_p = int'(p);
        mon = 1;
        cmd = {3'b000, nack, is_rd, ~is_rd, do_stop, 1'b1};
        write_reg(2'd1, cmd);
        quarters   = 4 + 36 + (do_stop ? 4 : 0);
        exp_cycles = quarters * (int'(p) + 1) + (stretch_bit >= 0 ? 20 : 0);
        busy_cnt = 0; seen = 0; done = 0;
        for (int i = 0; i < exp_cycles + 100; i++) begin
            @(negedge clk);
            if (i == inject + 1) begin chipselect = 1'b0; write_n = 1'b1; end
            if (i == inject) begin writedata = 8'h0D; chipselect = 1'b1; write_n = 1'b0; end
            if (readdata[0]) begin busy_cnt++; seen = 1; end
            else if (seen) begin done = 1; break; end
        end
        chipselect = 1'b0; write_n = 1'b1;
        check("busy_done", int'(done), 1);
        check("busy_cycles", busy_cnt, exp_cycles);
        if (do_stop) begin
            check("lines_released", int'({scl_oe, sda_oe}), 0);
            check("stop_seen", nstop, 1);
        end
        mon = 0;
        @(negedge clk);
        check("rise_count", nrise, 9 + (do_stop ? 1 : 0));
        for (int i = 0; i < 8 && i < nrise; i++)
            check($sformatf("bit%0d", i), int'(rise_bits[i]), int'(byte_v[7-i]));
        if (nrise > 8)
            check("ack_bit", int'(rise_bits[8]), is_rd ? int'(nack) : int'(!ack));
        if (is_rd && nack) check("ack_oe_released", int'(ack_oe_any), 0);
        if (!is_rd) exp_rxnack = !ack;
        read_reg(2'd1, rd);
        check("status", int'(rd), {exp_rxnack, 1'b0});
        if (is_rd) begin
            read_reg(2'd0, rd);
            check("rxdata", int'(rd), int'(byte_v));
        end
    endtask

    initial begin
        logic [7:0] rd;
        repeat (3) @(negedge clk);
        check("rst_readdata", int'(readdata), 0);
        check("rst_lines", int'({scl_oe, sda_oe}), 0);
        reset = 1'b0;
        read_reg(2'd1, rd); check("rst_status", int'(rd), 0);
        read_reg(2'd2, rd); check("rst_prescale", int'(rd), 8'h7C);
        read_reg(2'd3, rd); check("undef_addr", int'(rd), 0);

        run_txn(8'd3, 1, 0, 0, 8'hA5, 1, -1, -10);   // write, slave ACK
        run_txn(8'd3, 1, 0, 0, 8'hA5, 0, -1, -10);   // write, no slave
        run_txn(8'd3, 0, 1, 1, 8'h3C, 0, -1, -10);   // READ|NACK, no STOP
        run_txn(8'd3, 1, 0, 0, 8'hA5, 1, 3, -10);    // clock stretch in bit 3
        run_txn(8'd3, 1, 0, 0, 8'h96, 1, -1, 30);    // CMD while busy

        for (int k = 0; k < 10; k++) begin
            logic [7:0] p, b;
            bit st, r, n, a;
            int sb;
            p  = 8'($urandom_range(2, 5));
            b  = 8'($urandom);
            st = 1'($urandom);
            r  = 1'($urandom);
            n  = 1'($urandom);
            a  = 1'($urandom);
            sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_txn(p, st, r, n, b, a, sb, -10);
        end

        // Reset in the middle of a byte aborts at once.
        write_reg(2'd2, 8'd3);
        write_reg(2'd0, 8'h5A);
        write_reg(2'd1, 8'h07);
        repeat (49) @(negedge clk);
        check("busy_mid", int'(readdata[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_lines", int'({scl_oe, sda_oe}), 0);
        reset = 1'b0;
        exp_rxnack = 0;
        read_reg(2'd1, rd); check("abort_status", int'(rd), 0);
        read_reg(2'd2, rd); check("abort_prescale", int'(rd), 8'h7C);
        repeat (10) @(negedge clk);
        check("abort_quiet", int'({scl_oe, sda_oe}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
